// File: rtl/seq_counter_gen.sv
// seq_counter_gen: mode-selectable WIDTH-bit sequence counter (binary, Gray, Johnson, ring, LFSR)
module seq_counter_gen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QB,
  output logic             tc
);
  if (WIDTH < 3 || WIDTH > 8) begin : g_bad_width
    $error("seq_counter_gen: WIDTH must be in 3..8");
  end
  // Fibonacci tap masks, bit t-1 set for each tap t
  localparam logic [7:0] taps_all = (WIDTH == 3) ? 8'h06 :
                                    (WIDTH == 4) ? 8'h0c :
                                    (WIDTH == 5) ? 8'h14 :
                                    (WIDTH == 6) ? 8'h30 :
                                    (WIDTH == 7) ? 8'h60 : 8'hb8;
  localparam logic [WIDTH-1:0] taps = taps_all[WIDTH-1:0];
  localparam logic [WIDTH-1:0] one  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ones = '1;
  localparam logic [WIDTH-1:0] msb  = one << (WIDTH - 1);
  logic [WIDTH-1:0] q_q, q_d, step, bin_nxt, gray_nxt, nq, term;
  logic             j_legal, one_hot;
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  always_comb begin
    nq       = ~q_q;
    bin_nxt  = gray2bin(q_q) + one;
    gray_nxt = bin_nxt ^ (bin_nxt >> 1);
    j_legal  = ((q_q & (q_q + one)) == '0) || ((nq & (nq + one)) == '0);
    one_hot  = (q_q != '0) && ((q_q & (q_q - one)) == '0);
    step     = (mode == 3'd0) ? q_q + one :
               (mode == 3'd1) ? q_q - one :
               (mode == 3'd2) ? gray_nxt :
               (mode == 3'd3) ? (j_legal ? {~q_q[0], q_q[WIDTH-1:1]} : '0) :
               (mode == 3'd4) ? (one_hot ? {q_q[0], q_q[WIDTH-1:1]} : one) :
               (mode == 3'd5) ? ((q_q == '0) ? one : {q_q[WIDTH-2:0], ^(q_q & taps)}) :
               q_q;
    q_d      = load ? din : en ? step : q_q;
    term     = (mode == 3'd0) ? ones :
               (mode == 3'd1) ? '0 :
               (mode == 3'd3) ? one :
               (mode == 3'd4) ? (one << 1) : msb;
  end
  always_ff @(posedge clk) begin
    if (!clr) q_q <= '0;
    else      q_q <= q_d;
  end
  assign Q  = q_q;
  assign QB = ~q_q;
  assign tc = clr & en & ~load & (mode <= 3'd5) & (q_q == term);
endmodule

// File: tb/tb_seq_counter_gen.sv
// tb_seq_counter_gen: directed and random checks of WIDTH=4 and WIDTH=8 counters against a table/arithmetic model
module tb_seq_counter_gen;
  logic       clk = 1'b0;
  logic       clr, en, load;
  logic [2:0] mode;
  logic [7:0] din;
  logic [3:0] q4, qb4;
  logic [7:0] q8, qb8;
  logic       tc4, tc8;
  int errors = 0, checks = 0;
  int m4 = 0, m8 = 0;
  always #5 clk = ~clk;
  seq_counter_gen #(.WIDTH(4)) u4 (.clk(clk), .clr(clr), .en(en), .load(load), .mode(mode),
                                   .din(din[3:0]), .Q(q4), .QB(qb4), .tc(tc4));
  seq_counter_gen #(.WIDTH(8)) u8 (.clk(clk), .clr(clr), .en(en), .load(load), .mode(mode),
                                   .din(din), .Q(q8), .QB(qb8), .tc(tc8));
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic int term(int w, int m);
    case (m)
      0: return (1 << w) - 1;
      1: return 0;
      2: return 1 << (w - 1);
      3: return 1;
      4: return 2;
      5: return 1 << (w - 1);
      default: return -1;
    endcase
  endfunction
  function automatic int nxt(int w, int m, int q);
    int mask, n, fb, t2;
    int js[16];
    mask = (1 << w) - 1;
    case (m)
      0: return (q + 1) & mask;
      1: return (q + mask) & mask;
      2: begin
        for (int i = 0; i <= mask; i++)
          if ((i ^ (i >> 1)) == q) begin
            n = (i + 1) & mask;
            return n ^ (n >> 1);
          end
        return -1;
      end
      3: begin
        for (int k = 0; k < w; k++) begin
          js[k]     = mask ^ ((1 << (w - k)) - 1);
          js[w + k] = (1 << (w - k)) - 1;
        end
        for (int i = 0; i < 2 * w; i++)
          if (js[i] == q) return js[(i + 1) % (2 * w)];
        return 0;
      end
      4: begin
        for (int k = 0; k < w; k++)
          if (q == (1 << k)) return 1 << ((k + w - 1) % w);
        return 1;
      end
      5: begin
        if (q == 0) return 1;
        if (w == 8) fb = ((q >> 7) ^ (q >> 5) ^ (q >> 4) ^ (q >> 3)) & 1;
        else begin
          t2 = (w == 5) ? 3 : w - 1;
          fb = ((q >> (w - 1)) ^ (q >> (t2 - 1))) & 1;
        end
        return ((q << 1) | fb) & mask;
      end
      default: return q;
    endcase
  endfunction
  function automatic int mdl(int w, bit c, bit l, bit e, int m, int d, int q);
    if (!c) return 0;
    if (l) return d & ((1 << w) - 1);
    if (e) return nxt(w, m, q);
    return q;
  endfunction
  function automatic logic exp_tc(int w, int m, bit c, bit l, bit e, int q);
    return c && e && !l && (q == term(w, m));
  endfunction
  task automatic tick(input bit c, input bit l, input bit e, input int m, input int d);
    clr = c; load = l; en = e; mode = 3'(m); din = 8'(d);
    #1;
    chk("tc4", {7'b0, tc4}, {7'b0, exp_tc(4, m, c, l, e, m4)});
    chk("tc8", {7'b0, tc8}, {7'b0, exp_tc(8, m, c, l, e, m8)});
    m4 = mdl(4, c, l, e, m, d, m4);
    m8 = mdl(8, c, l, e, m, d, m8);
    @(posedge clk);
    #1;
    chk("q4", {4'b0, q4}, 8'(m4));
    chk("qb4", {4'b0, qb4}, 8'(~m4 & 15));
    chk("q8", q8, 8'(m8));
    chk("qb8", qb8, 8'(~m8 & 255));
    @(negedge clk);
  endtask
  bit seen[256];
  int distinct, tcs;
  initial begin
    clr = 0; load = 0; en = 0; mode = 0; din = 0;
    @(negedge clk);
    tick(0, 0, 0, 3, 0);
    tick(0, 1, 1, 0, 9);
    for (int i = 0; i < 8; i++) tick(1, 0, 1, 3, 0);
    chk("legacy_end", {4'b0, q4}, 8'h00);
    tick(1, 1, 1, 0, 8'h0e);
    tick(1, 0, 1, 0, 0);
    tick(1, 0, 1, 0, 0);
    tick(1, 0, 1, 1, 0);
    tick(1, 1, 0, 2, 0);
    for (int i = 0; i < 16; i++) tick(1, 0, 1, 2, 0);
    chk("gray_wrap", {4'b0, q4}, 8'h00);
    tick(1, 1, 0, 3, 5);
    tick(1, 0, 1, 3, 0);
    tick(1, 1, 0, 4, 6);
    tick(1, 0, 1, 4, 0);
    tick(1, 1, 0, 5, 0);
    tick(1, 0, 1, 5, 0);
    tick(1, 1, 0, 4, 1);
    for (int i = 0; i < 4; i++) tick(1, 0, 1, 4, 0);
    tick(1, 1, 0, 3, 0);
    tick(1, 0, 1, 3, 0);
    tick(1, 0, 1, 3, 0);
    tick(0, 0, 1, 3, 0);
    tick(1, 1, 1, 0, 8'ha5);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 0, 1, 6, 0);
    for (int i = 0; i < 4; i++) tick(1, 0, 1, 7, 0);
    tick(1, 1, 0, 0, 2);
    tick(1, 0, 1, 0, 0);
    tick(1, 0, 1, 3, 0);
    tick(1, 1, 0, 5, 1);
    distinct = 0; tcs = 0;
    for (int i = 0; i < 255; i++) begin
      clr = 1; load = 0; en = 1; mode = 5; #1;
      if (tc8) tcs++;
      tick(1, 0, 1, 5, 0);
      if (!seen[q8]) distinct++;
      seen[q8] = 1'b1;
    end
    chk("lfsr_distinct", 8'(distinct), 8'd255);
    chk("lfsr_tc_count", 8'(tcs), 8'd1);
    chk("lfsr_return", q8, 8'h01);
    for (int i = 0; i < 300; i++)
      tick($urandom_range(0, 15) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
